// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode constants, master FSM state
// encoding, transfer-size type and the expected-response helper.
// No ports (package).
package tl_pkg;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam int SOURCE_W = 8;

    typedef logic [1:0] tl_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } tl_state_e;

    // D-channel opcode a well-behaved slave answers with for a given request kind.
    function automatic logic [2:0] tl_expected_d_opcode(input logic is_write);
        if (is_write) begin
            return TL_ACCESS_ACK;
        end else begin
            return TL_ACCESS_ACK_DATA;
        end
    endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL link bundle (A and D channels, single 64-bit beat).
// Modports: master (drives A fields and d_ready), slave (drives a_ready and D fields).
interface tilelink;
    import tl_pkg::*;

    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    tl_size_t            a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [63:0]         a_address;
    logic [7:0]          a_mask;
    logic [63:0]         a_data;
    logic                a_corrupt;

    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    tl_size_t            d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_denied;
    logic [63:0]         d_data;
    logic                d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        input  d_ready
    );

endinterface

// File: rtl/tl_mask_gen.sv
// Byte-lane mask generator for a naturally aligned single-beat access.
// Ports: size (log2 bytes, 0..3), addr_lo (address bits [2:0]), mask (8-bit byte enables).
// Purely combinational; low address bits below the transfer size are ignored.
module tl_mask_gen
    import tl_pkg::*;
(
    input  tl_size_t   size,
    input  logic [2:0] addr_lo,
    output logic [7:0] mask
);

    // Shift a size-wide run of ones to the aligned lane selected by addr_lo.
    always_comb begin
        mask = 8'h00;
        case (size)
            2'd0:    mask = 8'h01 << addr_lo;
            2'd1:    mask = 8'h03 << {addr_lo[2:1], 1'b0};
            2'd2:    mask = 8'h0F << {addr_lo[2], 2'b00};
            2'd3:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
    end

endmodule

// File: rtl/tl_ul_master.sv
// TileLink-UL initiator: converts one client read/write request into a single
// Get/PutFullData A beat and returns the matching D response as a one-cycle pulse.
// One transaction outstanding at a time.
// Ports: clk, rst_n (synchronous, active-low); client side req_valid/req_ready/
//   req_write/req_addr/req_size/req_wdata and rsp_valid/rsp_data/rsp_err;
//   bus (tilelink.master modport).
// Optional feature macro: TL_MASTER_TIMEOUT_EN -- abort S_WAIT after
//   TIMEOUT_CYCLES cycles with rsp_err=1. Without it S_WAIT waits indefinitely.
module tl_ul_master
    import tl_pkg::*;
#(
    parameter int unsigned SOURCE_ID      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  tl_size_t    req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    tilelink.master     bus
);

    tl_state_e   state_r, state_s;
    logic        req_ready_r, a_valid_r, d_ready_r, rsp_valid_r, rsp_err_r;
    logic        write_r;
    logic [2:0]  a_opcode_r;
    tl_size_t    a_size_r;
    logic [63:0] a_address_r, a_data_r, rsp_data_r;
    logic [7:0]  a_mask_r, mask_s;
    logic        d_hit_s, timeout_s, rsp_load_s, rsp_err_s;
    logic [63:0] rsp_data_s;
    logic        unused_d_fields_s;

    assign unused_d_fields_s = ^{bus.d_param, bus.d_size};

    tl_mask_gen u_mask_gen (
        .size    (req_size),
        .addr_lo (req_addr[2:0]),
        .mask    (mask_s)
    );

    // Only beats tagged with our source count as our response.
    assign d_hit_s = bus.d_valid && (bus.d_source == SOURCE_W'(SOURCE_ID));

`ifdef TL_MASTER_TIMEOUT_EN
    logic [31:0] wait_cnt_r;

    // Wait-cycle counter: held at zero outside S_WAIT, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= 32'd0;
        end else if (state_r != S_WAIT) begin
            wait_cnt_r <= 32'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
        end
    end

    assign timeout_s = (state_r == S_WAIT) && (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // Next-state logic and the response value to capture on leaving S_WAIT.
    always_comb begin
        state_s    = state_r;
        rsp_load_s = 1'b0;
        rsp_data_s = 64'h0;
        rsp_err_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.a_ready) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (d_hit_s) begin
                    state_s    = S_RESP;
                    rsp_load_s = 1'b1;
                    rsp_err_s  = bus.d_denied | bus.d_corrupt |
                                 (bus.d_opcode != tl_expected_d_opcode(write_r));
                    if (write_r) begin
                        rsp_data_s = 64'h0;
                    end else begin
                        rsp_data_s = bus.d_data;
                    end
                end else if (timeout_s) begin
                    state_s    = S_RESP;
                    rsp_load_s = 1'b1;
                    rsp_err_s  = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, registered handshake outputs, request capture and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            req_ready_r <= 1'b1;
            a_valid_r   <= 1'b0;
            d_ready_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 64'h0;
            rsp_err_r   <= 1'b0;
            write_r     <= 1'b0;
            a_opcode_r  <= 3'd0;
            a_size_r    <= 2'd0;
            a_address_r <= 64'h0;
            a_mask_r    <= 8'h00;
            a_data_r    <= 64'h0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == S_IDLE);
            a_valid_r   <= (state_s == S_REQ);
            d_ready_r   <= (state_s == S_WAIT);
            rsp_valid_r <= (state_s == S_RESP);
            if (state_r == S_IDLE && req_valid) begin
                write_r     <= req_write;
                a_opcode_r  <= req_write ? TL_PUT_FULL_DATA : TL_GET;
                a_size_r    <= req_size;
                a_address_r <= req_addr;
                a_mask_r    <= mask_s;
                a_data_r    <= req_write ? req_wdata : 64'h0;
            end
            if (rsp_load_s) begin
                rsp_data_r <= rsp_data_s;
                rsp_err_r  <= rsp_err_s;
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;
    assign bus.a_valid   = a_valid_r;
    assign bus.a_opcode  = a_opcode_r;
    assign bus.a_param   = 3'd0;
    assign bus.a_size    = a_size_r;
    assign bus.a_source  = SOURCE_W'(SOURCE_ID);
    assign bus.a_address = a_address_r;
    assign bus.a_mask    = a_mask_r;
    assign bus.a_data    = a_data_r;
    assign bus.a_corrupt = 1'b0;
    assign bus.d_ready   = d_ready_r;

endmodule

// File: tb/tb_tl_ul_master.sv
// Directed bench for tl_ul_master: stimulus pushes expected responses into a
// scoreboard queue; a monitor pops and compares on every rsp_valid pulse.
module tb_tl_ul_master;
    import tl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [63:0] req_addr = 64'h0, req_wdata = 64'h0;
    tl_size_t    req_size = 2'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_data;

    tilelink bus_if();

    tl_ul_master #(.SOURCE_ID(0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          accept_cyc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int accept_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input logic [63:0] d, input logic e, input int lat);
        exp_t x;
        x.data = d; x.err = e; x.accept_cyc = accept_cyc; x.lat = lat;
        sb.push_back(x);
    endtask

    // Issue one request at a negedge with the DUT idle; returns one cycle later.
    task automatic send_req(input logic w, input logic [63:0] a, input tl_size_t s, input logic [63:0] wd);
        chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
        accept_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [7:0] src, input logic [63:0] d,
                          input logic den, input logic cor);
        bus_if.d_valid = 1'b1; bus_if.d_opcode = op; bus_if.d_source = src; bus_if.d_data = d;
        bus_if.d_denied = den; bus_if.d_corrupt = cor; bus_if.d_param = 2'd0; bus_if.d_size = 2'd3;
        @(negedge clk);
        bus_if.d_valid = 1'b0; bus_if.d_denied = 1'b0; bus_if.d_corrupt = 1'b0;
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'h1, 64'h0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("rsp_data", rsp_data, x.data);
                chk("rsp_err", {63'h0, rsp_err}, {63'h0, x.err});
                if (x.lat >= 0) chk("rsp_latency", 64'(cyc - x.accept_cyc), 64'(x.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.a_ready = 1'b0; bus_if.d_valid = 1'b0; bus_if.d_opcode = 3'd0; bus_if.d_param = 2'd0;
        bus_if.d_size = 2'd0; bus_if.d_source = 8'd0; bus_if.d_denied = 1'b0; bus_if.d_data = 64'h0;
        bus_if.d_corrupt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_a_valid", {63'h0, bus_if.a_valid}, 64'h0);
        chk("rst_d_ready", {63'h0, bus_if.d_ready}, 64'h0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        rst_n = 1'b1;

        // 1: Get, full 8-byte lane, 1-cycle slave
        bus_if.a_ready = 1'b1;
        send_req(1'b0, 64'h100, 2'd3, 64'h0);
        chk("t1_a_valid", {63'h0, bus_if.a_valid}, 64'h1);
        chk("t1_a_opcode", {61'h0, bus_if.a_opcode}, 64'h4);
        chk("t1_a_mask", {56'h0, bus_if.a_mask}, 64'hFF);
        chk("t1_a_address", bus_if.a_address, 64'h100);
        chk("t1_a_size", {62'h0, bus_if.a_size}, 64'h3);
        chk("t1_a_data", bus_if.a_data, 64'h0);
        chk("t1_a_param_src_cor", {bus_if.a_param, bus_if.a_source, bus_if.a_corrupt}, 64'h0);
        chk("t1_req_ready_busy", {63'h0, req_ready}, 64'h0);
        @(negedge clk);
        chk("t1_d_ready", {63'h0, bus_if.d_ready}, 64'h1);
        expect_rsp(64'hDEADBEEF_CAFEF00D, 1'b0, 3);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
        @(negedge clk);

        // 2: Put single byte at lane 5
        send_req(1'b1, 64'h2005, 2'd0, 64'h0000_AB00_0000_0000);
        chk("t2_a_opcode", {61'h0, bus_if.a_opcode}, 64'h0);
        chk("t2_a_mask", {56'h0, bus_if.a_mask}, 64'h20);
        chk("t2_a_data", bus_if.a_data, 64'h0000_AB00_0000_0000);
        @(negedge clk);
        expect_rsp(64'h0, 1'b0, 3);
        d_beat(TL_ACCESS_ACK, 8'd0, 64'h1234, 1'b0, 1'b0);
        @(negedge clk);

        // 3: a_ready held low; a second request waits for the first to finish
        bus_if.a_ready = 1'b0;
        send_req(1'b0, 64'h300C, 2'd2, 64'h0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h4000; req_size = 2'd3;
        req_wdata = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 5; i++) begin
            chk("t3_a_valid_hold", {63'h0, bus_if.a_valid}, 64'h1);
            chk("t3_a_addr_hold", bus_if.a_address, 64'h300C);
            chk("t3_a_fields_hold", {bus_if.a_opcode, bus_if.a_size, bus_if.a_mask}, {3'd4, 2'd2, 8'hF0});
            chk("t3_req_ready_low", {63'h0, req_ready}, 64'h0);
            @(negedge clk);
        end
        bus_if.a_ready = 1'b1;
        @(negedge clk);
        expect_rsp(64'h1111_2222_3333_4444, 1'b0, -1);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        begin
            int waited = 0;
            while (req_ready !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            chk("t3_second_accept_wait", {63'h0, req_ready}, 64'h1);
        end
        accept_cyc = cyc;
        expect_rsp(64'h0, 1'b0, -1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t3_b_a_address", bus_if.a_address, 64'h4000);
        chk("t3_b_a_fields", {bus_if.a_opcode, bus_if.a_mask}, {3'd0, 8'hFF});
        chk("t3_b_a_data", bus_if.a_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        d_beat(TL_ACCESS_ACK, 8'd0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);

        // 4: wrong source ignored, then denied response
        send_req(1'b0, 64'h502, 2'd1, 64'h0);
        chk("t4_a_mask", {56'h0, bus_if.a_mask}, 64'h0C);
        @(negedge clk);
        d_beat(TL_ACCESS_ACK_DATA, 8'd1, 64'hBAD, 1'b0, 1'b0);
        chk("t4_still_waiting", {63'h0, bus_if.d_ready}, 64'h1);
        expect_rsp(64'h5555_6666_7777_8888, 1'b1, -1);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
        @(negedge clk);
        // 4b: Put answered with AccessAckData -> opcode mismatch
        send_req(1'b1, 64'h600, 2'd3, 64'hFFFF);
        @(negedge clk);
        expect_rsp(64'h0, 1'b1, -1);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'h77, 1'b0, 1'b0);
        @(negedge clk);
        // 4c: corrupt read data
        send_req(1'b0, 64'h608, 2'd3, 64'h0);
        @(negedge clk);
        expect_rsp(64'h99, 1'b1, -1);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'h99, 1'b0, 1'b1);
        @(negedge clk);

        // 5: reset while waiting for D
        send_req(1'b0, 64'h700, 2'd3, 64'h0);
        @(negedge clk);
        chk("t5_in_wait", {63'h0, bus_if.d_ready}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_a_valid", {63'h0, bus_if.a_valid}, 64'h0);
        chk("t5_d_ready", {63'h0, bus_if.d_ready}, 64'h0);
        chk("t5_rsp", {rsp_valid, rsp_err}, 64'h0);
        chk("t5_rsp_data", rsp_data, 64'h0);
        chk("t5_a_fields", {bus_if.a_opcode, bus_if.a_size, bus_if.a_mask}, 64'h0);
        chk("t5_a_address", bus_if.a_address, 64'h0);
        rst_n = 1'b1;
        send_req(1'b0, 64'h800, 2'd3, 64'h0);
        @(negedge clk);
        expect_rsp(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 3);
        d_beat(TL_ACCESS_ACK_DATA, 8'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b0);
        @(negedge clk);

`ifdef TL_MASTER_TIMEOUT_EN
        // 6: silent slave -> timeout 16 cycles after S_WAIT entry
        send_req(1'b0, 64'h900, 2'd3, 64'h0);
        expect_rsp(64'h0, 1'b1, 18);
        begin
            int waited = 0;
            while (sb.size() != 0 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
